// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
    parameter int unsigned CLOCK_RATE     = 100_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLOCKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BitLast  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            rx_meta;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_ok;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_ok     <= 1'b1;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    cnt <= '0;
                    if (!rx_s) state <= StStart;
                end
                StStart: begin
                    if (cnt == HalfLast) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is high at mid-bit was a glitch.
                        state   <= rx_s ? StIdle : StData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == BitLast) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt == BitLast) begin
                        cnt    <= '0;
                        par_ok <= ~(^shreg ^ rx_s);
                        state  <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (cnt == BitLast) begin
                        cnt <= '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_ok) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
`else
                            data  <= shreg;
                            valid <= 1'b1;
`endif
                            // Back to idle at mid-stop so a following start bit is not missed.
                            state <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StWaitHigh;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rx_s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
